// File: rtl/dmux4_stream.sv
// -----------------------------------------------------------------------------
// dmux4_stream
//   1-to-4 registered demultiplexer. One producer on a valid/ready channel is
//   steered to one of four consumers chosen by in_sel. Each output channel has
//   a one-entry holding register, its own backpressure and a counter of words
//   delivered on that channel.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer offers a word
//   in_ready   block accepts the word this cycle (depends on addressed channel)
//   in_sel     destination channel 0..3, sampled together with in_data
//   in_data    word to route
//   out_valid  bit k: channel k holds a word
//   out_ready  bit k: consumer k takes the word this cycle
//   out_data   channel k word at bits [k*WIDTH +: WIDTH]
//   out_count  channel k delivered-word count at bits [k*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module dmux4_stream #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [4*CNT_W-1:0]   out_count
);

    logic [3:0]             buf_valid_q, buf_valid_d;
    logic [3:0][WIDTH-1:0]  buf_data_q,  buf_data_d;
    logic [3:0][CNT_W-1:0]  cnt_q,       cnt_d;
    logic                   accept;
    logic [3:0]             fill;
    logic [3:0]             drain;

    // Only the addressed channel gates the producer: a stalled channel never
    // blocks traffic headed elsewhere. A full channel that is draining this
    // cycle can still take a new word, giving one word per cycle per channel.
    assign in_ready = !buf_valid_q[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        cnt_d       = cnt_q;
        fill        = '0;
        drain       = '0;
        for (int k = 0; k < 4; k++) begin
            drain[k] = buf_valid_q[k] && out_ready[k];
            fill[k]  = accept && (in_sel == 2'(k));
            // Fill wins over drain so a simultaneous drain+fill keeps the
            // buffer occupied with the new word.
            if (fill[k]) begin
                buf_valid_d[k] = 1'b1;
                buf_data_d[k]  = in_data;
            end else if (drain[k]) begin
                buf_valid_d[k] = 1'b0;
            end
            if (drain[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= '0;
            buf_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            cnt_q       <= cnt_d;
        end
    end

    // Outputs come straight from registers; no path from in_data to out_data.
    assign out_valid = buf_valid_q;
    assign out_data  = buf_data_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_dmux4_stream.sv
module tb_dmux4_stream;

    localparam int W  = 16;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_sel = 2'd0;
    logic [W-1:0]      in_data = '0;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready = 4'h0;
    logic [4*W-1:0]    out_data;
    logic [4*CW-1:0]   out_count;

    dmux4_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [3:0]  rdy;
        logic        exp_rdy;
    } vec_t;

    vec_t        tbl [11];
    logic [15:0] sbq [4][$];
    logic [7:0]  exp_cnt [4];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            sbq[k].delete();
            exp_cnt[k] = 8'd0;
        end
    endtask

    // Called just after a falling edge. Drives one cycle of stimulus, checks
    // the DUT against the scoreboard, then advances past the next rising edge.
    task automatic step(input logic v, input logic [1:0] s, input logic [15:0] d,
                        input logic [3:0] r, input logic has_exp, input logic exp_rdy);
        logic mdl_rdy;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        mdl_rdy = (sbq[s].size() == 0) || r[s];
        chk("in_ready", 64'(in_ready), 64'(mdl_rdy));
        if (has_exp) chk("in_ready_tbl", 64'(in_ready), 64'(exp_rdy));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(sbq[k].size() != 0));
            if (sbq[k].size() != 0)
                chk($sformatf("out_data[%0d]", k), 64'(out_data[k*W +: W]), 64'(sbq[k][0]));
            chk($sformatf("out_count[%0d]", k), 64'(out_count[k*CW +: CW]), 64'(exp_cnt[k]));
        end
        for (int k = 0; k < 4; k++) begin
            if (sbq[k].size() != 0 && r[k]) begin
                void'(sbq[k].pop_front());
                exp_cnt[k] = exp_cnt[k] + 8'd1;
            end
        end
        if (v && mdl_rdy) sbq[s].push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_tbl(input int lo, input int hi);
        for (int i = lo; i < hi; i++)
            step(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].rdy, 1'b1, tbl[i].exp_rdy);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'($urandom_range(0, 3));
        in_data   = 16'($urandom);
        out_ready = 4'($urandom);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data",  64'(out_data),  64'h0);
        chk("rst_out_count", 64'(out_count), 64'h0);
        chk("rst_in_ready",  64'(in_ready),  64'h1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_valid", 64'(out_valid), 64'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        clear_model();
    endtask

    initial begin
        // routing: all consumers ready
        tbl[0]  = '{1'b1, 2'd0, 16'hA001, 4'hF, 1'b1};
        tbl[1]  = '{1'b1, 2'd1, 16'hB002, 4'hF, 1'b1};
        tbl[2]  = '{1'b1, 2'd2, 16'hC003, 4'hF, 1'b1};
        tbl[3]  = '{1'b1, 2'd3, 16'hD004, 4'hF, 1'b1};
        tbl[4]  = '{1'b0, 2'd0, 16'h0000, 4'hF, 1'b1};
        // backpressure on channel 2
        tbl[5]  = '{1'b1, 2'd2, 16'h1111, 4'hB, 1'b1};
        tbl[6]  = '{1'b1, 2'd2, 16'h2222, 4'hB, 1'b0};
        tbl[7]  = '{1'b1, 2'd0, 16'h3333, 4'hB, 1'b1};
        tbl[8]  = '{1'b1, 2'd2, 16'h2222, 4'hB, 1'b0};
        tbl[9]  = '{1'b1, 2'd2, 16'h2222, 4'hF, 1'b1};
        tbl[10] = '{1'b0, 2'd2, 16'h0000, 4'hF, 1'b1};

        clear_model();
        @(negedge clk);
        do_reset();

        run_tbl(0, 5);
        chk("route_counts", 64'(out_count), 64'h01010101);

        do_reset();
        run_tbl(5, 11);
        chk("bp_cnt2", 64'(out_count[2*CW +: CW]), 64'd2);
        chk("bp_cnt0", 64'(out_count[0*CW +: CW]), 64'd1);

        // streaming: 8 back-to-back words on channel 1
        do_reset();
        for (int i = 0; i < 8; i++)
            step(1'b1, 2'd1, 16'h7000 + 16'(i), 4'b0010, 1'b1, 1'b1);
        step(1'b0, 2'd1, 16'h0000, 4'b0010, 1'b0, 1'b0);
        chk("stream_cnt1", 64'(out_count[1*CW +: CW]), 64'd8);

        // counter wrap on channel 3
        do_reset();
        for (int i = 0; i < 256; i++)
            step(1'b1, 2'd3, 16'(i * 7 + 3), 4'b1000, 1'b0, 1'b0);
        step(1'b0, 2'd3, 16'h0000, 4'b1000, 1'b0, 1'b0);
        chk("wrap_cnt3_0", 64'(out_count[3*CW +: CW]), 64'd0);
        step(1'b1, 2'd3, 16'hBEEF, 4'b1000, 1'b0, 1'b0);
        step(1'b0, 2'd3, 16'h0000, 4'b1000, 1'b0, 1'b0);
        chk("wrap_cnt3_1", 64'(out_count[3*CW +: CW]), 64'd1);

        // reset mid-operation with channels 0 and 2 full and stalled
        do_reset();
        step(1'b1, 2'd0, 16'hAAAA, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 2'd2, 16'hBBBB, 4'b0000, 1'b0, 1'b0);
        in_valid = 1'b0;
        in_sel   = 2'd2;
        #1;
        chk("mid_full_valid", 64'(out_valid), 64'b0101);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_count", 64'(out_count), 64'h0);
        chk("mid_rst_data",  64'(out_data),  64'h0);
        chk("mid_rst_ready", 64'(in_ready),  64'h1);
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        step(1'b1, 2'd2, 16'h5A5A, 4'b0100, 1'b1, 1'b1);
        step(1'b0, 2'd2, 16'h0000, 4'b0100, 1'b0, 1'b0);
        chk("mid_after_cnt2", 64'(out_count[2*CW +: CW]), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
